imem_resp: RTL and testbench

Instruction-memory responder at the far end of the fetch path. The PC stage issues fetch addresses; this block accepts each address over a valid/ready request channel, reads a word from its internal instruction RAM after a fixed latency, and returns the instruction, or an access error, over a valid/ready response channel. A side-band load port fills the RAM before and during simulation.

---
 rtl/imem_resp.sv | 124 ++++++++++++
 tb/tb_imem_resp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_resp.sv
// Instruction RAM responder: one fetch in flight, returns word or access error with echoed address.
// Latency: rsp_valid rises LATENCY cycles after the request handshake cycle.
// Backpressure: rsp_* held while rsp_ready=0; req_ready follows rsp_ready combinationally in RESP.
module imem_resp #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_inst,
    output logic                     rsp_err,
    output logic [31:0]              rsp_addr,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [31:0]              ld_data
);
    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = $clog2(LATENCY + 1);
    localparam logic [CW-1:0]   CNT_INIT  = CW'(LATENCY - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [32:0]     RAM_BYTES = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [31:0]   addr_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          load_rsp;
    logic [31:0]   rd_addr;
    logic [31:0]   rd_off;
    logic          rd_err;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_rsp  = 1'b0;
        req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
        accept    = req_valid && req_ready;

        case (state)
            IDLE: ;
            WAIT: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_nxt = RESP;
                    load_rsp  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A new accept overrides the RESP drain; with single-cycle latency it also captures now.
        if (accept) begin
            cnt_nxt = CNT_INIT;
            if (LATENCY > 1) begin
                state_nxt = WAIT;
            end else begin
                state_nxt = RESP;
                load_rsp  = 1'b1;
            end
        end
    end

    // Single-cycle latency captures on the accept edge, before addr_q holds the new address.
    always_comb begin
        rd_addr = accept ? req_addr : addr_q;
        rd_off  = rd_addr - BASE_ADDR;
        rd_err  = (rd_addr[1:0] != 2'b00) || (rd_addr < BASE_ADDR) ||
                  ({1'b0, rd_off} >= RAM_BYTES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_inst  <= '0;
            rsp_err   <= 1'b0;
            rsp_addr  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q <= req_addr;
            end
            if (load_rsp) begin
                rsp_valid <= 1'b1;
                rsp_addr  <= rd_addr;
                rsp_err   <= rd_err;
                rsp_inst  <= rd_err ? 32'h0 : mem[rd_off[AW+1:2]];
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Loads ignore reset; a same-edge read above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end
endmodule

// File: tb/tb_imem_resp.sv
// Scoreboard bench for imem_resp at LATENCY=2 (dut2) and LATENCY=1 (dut1).
module tb_imem_resp;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst2, req_valid2, req_ready2, rsp_valid2, rsp_ready2, rsp_err2, ld_en2;
    logic [31:0] req_addr2, rsp_inst2, rsp_addr2, ld_data2;
    logic [9:0]  ld_idx2;
    logic        rst1, req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1, ld_en1;
    logic [31:0] req_addr1, rsp_inst1, rsp_addr1, ld_data1;
    logic [9:0]  ld_idx1;

    exp_t q2[$];
    exp_t q1[$];
    exp_t e2, e1;
    int   n_pass = 0;
    int   n_tot  = 0;

    logic [31:0] img [8] = '{32'h00100073, 32'h00000013, 32'h00a00093, 32'h00b00113,
                             32'h002081b3, 32'h40208233, 32'h0000006f, 32'hfe000ee3};
    localparam logic [31:0] W1023 = 32'hcafef00d;

    always #5 clk = ~clk;

    imem_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_addr(req_addr2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_inst(rsp_inst2), .rsp_err(rsp_err2), .rsp_addr(rsp_addr2),
        .ld_en(ld_en2), .ld_idx(ld_idx2), .ld_data(ld_data2)
    );

    imem_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_inst(rsp_inst1), .rsp_err(rsp_err1), .rsp_addr(rsp_addr1),
        .ld_en(ld_en1), .ld_idx(ld_idx1), .ld_data(ld_data1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request, wait (bounded) for the handshake, then queue its expectation.
    task automatic send(input bit d1, input logic [31:0] a, input logic [31:0] inst,
                        input logic err, input bit push, output int waited);
        logic rdy;
        exp_t x;
        waited = 0;
        rdy    = 1'b0;
        if (d1) begin req_valid1 = 1'b1; req_addr1 = a; end
        else    begin req_valid2 = 1'b1; req_addr2 = a; end
        forever begin
            @(negedge clk);
            rdy = d1 ? req_ready1 : req_ready2;
            tick();
            if (rdy === 1'b1) break;
            waited++;
            if (waited > 50) begin
                n_tot++;
                $display("FAIL send_timeout: addr %h not accepted after %0d cycles", a, waited);
                break;
            end
        end
        if (d1) req_valid1 = 1'b0; else req_valid2 = 1'b0;
        if (rdy === 1'b1 && push) begin
            x.addr = a; x.inst = inst; x.err = err;
            if (d1) q1.push_back(x); else q2.push_back(x);
        end
    endtask

    task automatic chk_lat2(input string name);
        @(negedge clk);
        check({name, "_wait"}, {31'b0, rsp_valid2}, 32'd0);
        @(negedge clk);
        check({name, "_valid"}, {31'b0, rsp_valid2}, 32'd1);
        tick();
    endtask

    always @(negedge clk) begin
        if (rsp_valid2 === 1'b1 && rsp_ready2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_tot++;
                $display("FAIL mon2_extra: unexpected response addr %h", rsp_addr2);
            end else begin
                e2 = q2.pop_front();
                check("mon2_addr", rsp_addr2, e2.addr);
                check("mon2_inst", rsp_inst2, e2.inst);
                check("mon2_err", {31'b0, rsp_err2}, {31'b0, e2.err});
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid1 === 1'b1 && rsp_ready1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_tot++;
                $display("FAIL mon1_extra: unexpected response addr %h", rsp_addr1);
            end else begin
                e1 = q1.pop_front();
                check("mon1_addr", rsp_addr1, e1.addr);
                check("mon1_inst", rsp_inst1, e1.inst);
                check("mon1_err", {31'b0, rsp_err1}, {31'b0, e1.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int b;
        rst2 = 1'b1; req_valid2 = 1'b0; req_addr2 = '0; rsp_ready2 = 1'b1;
        ld_en2 = 1'b0; ld_idx2 = '0; ld_data2 = '0;
        rst1 = 1'b1; req_valid1 = 1'b0; req_addr1 = '0; rsp_ready1 = 1'b1;
        ld_en1 = 1'b0; ld_idx1 = '0; ld_data1 = '0;
        tick();

        // Preload both RAMs while reset is held.
        for (int k = 0; k < 9; k++) begin
            ld_en2  = 1'b1; ld_en1 = 1'b1;
            ld_idx2 = (k == 8) ? 10'd1023 : 10'(k);
            ld_data2 = (k == 8) ? W1023 : img[k];
            ld_idx1 = ld_idx2; ld_data1 = ld_data2;
            tick();
        end
        ld_en2 = 1'b0; ld_en1 = 1'b0;

        @(negedge clk);
        check("rst_valid", {31'b0, rsp_valid2}, 32'd0);
        check("rst_inst", rsp_inst2, 32'd0);
        check("rst_err", {31'b0, rsp_err2}, 32'd0);
        check("rst_addr", rsp_addr2, 32'd0);
        tick();
        rst2 = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", {31'b0, req_ready2}, 32'd1);
        tick();

        // Aligned fetch
        send(1'b0, 32'h8000_0000, img[0], 1'b0, 1'b1, w);
        check("fetch0_wait", w, 0);
        chk_lat2("fetch0");

        // Backpressure
        rsp_ready2 = 1'b0;
        send(1'b0, 32'h8000_0004, img[1], 1'b0, 1'b1, w);
        req_valid2 = 1'b1; req_addr2 = 32'h8000_0008;
        b = 0;
        do begin @(negedge clk); b++; end while (rsp_valid2 !== 1'b1 && b < 20);
        check("bp_rsp_arrive", {31'b0, rsp_valid2}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_req_ready", {31'b0, req_ready2}, 32'd0);
            check("bp_hold_valid", {31'b0, rsp_valid2}, 32'd1);
            check("bp_hold_addr", rsp_addr2, 32'h8000_0004);
            check("bp_hold_inst", rsp_inst2, img[1]);
            check("bp_hold_err", {31'b0, rsp_err2}, 32'd0);
            if (i < 4) @(negedge clk);
        end
        tick();
        rsp_ready2 = 1'b1;
        send(1'b0, 32'h8000_0008, img[2], 1'b0, 1'b1, w);
        check("bp_accept_wait", w, 0);
        chk_lat2("bp_second");

        // Error cases and last valid word
        send(1'b0, 32'h8000_0002, 32'h0, 1'b1, 1'b1, w); chk_lat2("err_misalign");
        send(1'b0, 32'h7FFF_FFFC, 32'h0, 1'b1, 1'b1, w); chk_lat2("err_below");
        send(1'b0, 32'h8000_1000, 32'h0, 1'b1, 1'b1, w); chk_lat2("err_above");
        send(1'b0, 32'h8000_0FFC, W1023, 1'b0, 1'b1, w); chk_lat2("last_word");

        // Streaming: one response every two cycles
        for (int k = 0; k < 8; k++) begin
            send(1'b0, 32'h8000_0000 + 32'(4 * k), img[k], 1'b0, 1'b1, w);
            check("stream_gap", w, (k == 0) ? 0 : 1);
        end
        chk_lat2("stream_last");

        // Reset mid-WAIT abandons the request
        send(1'b0, 32'h8000_0010, img[4], 1'b0, 1'b0, w);
        rst2 = 1'b1;
        @(negedge clk);
        check("rstw_valid0", {31'b0, rsp_valid2}, 32'd0);
        tick();
        tick();
        rst2 = 1'b0;
        @(negedge clk);
        check("rstw_ready", {31'b0, req_ready2}, 32'd1);
        check("rstw_valid1", {31'b0, rsp_valid2}, 32'd0);
        @(negedge clk);
        check("rstw_valid2", {31'b0, rsp_valid2}, 32'd0);
        tick();
        send(1'b0, 32'h8000_0014, img[5], 1'b0, 1'b1, w);
        chk_lat2("rstw_next");

        // LATENCY=1: load collision on the capture edge
        @(negedge clk);
        check("l1_rst_valid", {31'b0, rsp_valid1}, 32'd0);
        check("l1_rst_inst", rsp_inst1, 32'd0);
        tick();
        rst1 = 1'b0;
        @(negedge clk);
        check("l1_rdy_after_rst", {31'b0, req_ready1}, 32'd1);
        tick();
        ld_en1 = 1'b1; ld_idx1 = 10'd3; ld_data1 = 32'hDEAD_BEEF;
        send(1'b1, 32'h8000_000C, img[3], 1'b0, 1'b1, w);
        ld_en1 = 1'b0;
        check("l1_coll_wait", w, 0);
        send(1'b1, 32'h8000_000C, 32'hDEAD_BEEF, 1'b0, 1'b1, w);
        check("l1_b2b_wait", w, 0);
        @(negedge clk);
        check("l1_refetch_valid", {31'b0, rsp_valid1}, 32'd1);
        tick();
        tick();

        check("q2_drained", q2.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
